rate_detector: RTL and testbench

- Receive-side counterpart of the rate-divider enable generator: watches a stream of single-cycle enable pulses and recovers the 2-bit Speed code that produced them.
- Measures the cycle interval between pulses and classifies it against the nominal periods: 1, CLOCK_FREQUENCY, 2*CLOCK_FREQUENCY and 4*CLOCK_FREQUENCY.
- Reports the code once it has been stable for LOCK_COUNT consecutive intervals.
- Used for self-check loopback of the rate divider and for decoding a tick line from another board.

---
 rtl/rate_detector.sv | 155 +++++++++++++++
 tb/tb_rate_detector.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/rate_detector.sv
// Recovers the 2-bit speed code from a stream of single-cycle enable pulses by
// measuring the pulse interval, classifying it, and locking after a stable streak.
module rate_detector #(
  parameter int CLOCK_FREQUENCY = 50000000,
  parameter int TOLERANCE       = 0,
  parameter int LOCK_COUNT      = 2,
  localparam int W              = $clog2(4*CLOCK_FREQUENCY+TOLERANCE+2)
) (
  input  logic         ClockIn,
  input  logic         Reset,
  input  logic         PulseIn,
  output logic [1:0]   SpeedOut,
  output logic         Locked,
  output logic [W-1:0] IntervalOut,
  output logic         MeasValid,
  output logic         Error
);

  localparam int MAXI = 4*CLOCK_FREQUENCY + TOLERANCE;
  localparam int SW   = $clog2(LOCK_COUNT+1);
  localparam logic [W-1:0]  MAXI_W = W'(MAXI);
  localparam logic [SW-1:0] LOCK_W = SW'(LOCK_COUNT);

  typedef enum logic [1:0] {IDLE, MEASURE, LOCKED} state_t;

  state_t        state_reg, state_next;
  logic [W-1:0]  cnt_reg, cnt_next;
  logic [1:0]    cand_reg, cand_next;
  logic [SW-1:0] streak_reg, streak_next;
  logic [1:0]    speed_reg, speed_next;
  logic          locked_reg, locked_next;
  logic [W-1:0]  interval_reg, interval_next;
  logic          meas_valid_reg, meas_valid_next;
  logic          error_reg, error_next;

  logic [W-1:0]  interval;
  logic [2:0]    band_hit;
  logic          matched;
  logic [1:0]    code;
  logic [SW-1:0] streak_inc;
  logic [SW-1:0] streak_new;

  assign interval = cnt_reg + W'(1);

  // Tolerance windows around 1x, 2x and 4x the nominal period
  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_band
      localparam int NOM = CLOCK_FREQUENCY << gi;
      localparam logic [W-1:0] LO = W'(NOM - TOLERANCE);
      localparam logic [W-1:0] HI = W'(NOM + TOLERANCE);
      assign band_hit[gi] = (interval >= LO) && (interval <= HI);
    end
  endgenerate

  always_comb begin
    matched = 1'b1;
    code    = 2'b00;
    if (interval == W'(1))   code = 2'b00;
    else if (band_hit[0])    code = 2'b01;
    else if (band_hit[1])    code = 2'b10;
    else if (band_hit[2])    code = 2'b11;
    else                     matched = 1'b0;
  end

  always_comb begin
    streak_inc = (streak_reg >= LOCK_W) ? streak_reg : streak_reg + SW'(1);
  end

  always_comb begin
    state_next      = state_reg;
    cnt_next        = cnt_reg;
    cand_next       = cand_reg;
    streak_next     = streak_reg;
    speed_next      = speed_reg;
    locked_next     = locked_reg;
    interval_next   = interval_reg;
    meas_valid_next = 1'b0;
    error_next      = 1'b0;
    streak_new      = streak_reg;

    case (state_reg)
      IDLE: begin
        cnt_next = '0;
        if (PulseIn) state_next = MEASURE;
      end
      MEASURE, LOCKED: begin
        if (PulseIn) begin
          cnt_next        = '0;
          interval_next   = interval;
          meas_valid_next = 1'b1;
          if (!matched) begin
            error_next  = 1'b1;
            streak_next = '0;
            locked_next = 1'b0;
            state_next  = MEASURE;
          end else if (!(state_reg == LOCKED && code == speed_reg)) begin
            // A new code seen while locked restarts the streak at one
            streak_new  = (state_reg == LOCKED || code != cand_reg) ? SW'(1) : streak_inc;
            cand_next   = code;
            streak_next = streak_new;
            if (streak_new >= LOCK_W) begin
              state_next  = LOCKED;
              speed_next  = code;
              locked_next = 1'b1;
            end else begin
              state_next  = MEASURE;
              locked_next = 1'b0;
            end
          end
        end else if (cnt_reg == MAXI_W) begin
          error_next  = 1'b1;
          state_next  = IDLE;
          locked_next = 1'b0;
          streak_next = '0;
          cnt_next    = '0;
        end else begin
          cnt_next = cnt_reg + W'(1);
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge ClockIn) begin
    if (Reset) begin
      state_reg      <= IDLE;
      cnt_reg        <= '0;
      cand_reg       <= 2'b00;
      streak_reg     <= '0;
      speed_reg      <= 2'b00;
      locked_reg     <= 1'b0;
      interval_reg   <= '0;
      meas_valid_reg <= 1'b0;
      error_reg      <= 1'b0;
    end else begin
      state_reg      <= state_next;
      cnt_reg        <= cnt_next;
      cand_reg       <= cand_next;
      streak_reg     <= streak_next;
      speed_reg      <= speed_next;
      locked_reg     <= locked_next;
      interval_reg   <= interval_next;
      meas_valid_reg <= meas_valid_next;
      error_reg      <= error_next;
    end
  end

  assign SpeedOut    = speed_reg;
  assign Locked      = locked_reg;
  assign IntervalOut = interval_reg;
  assign MeasValid   = meas_valid_reg;
  assign Error       = error_reg;

endmodule

// File: tb/tb_rate_detector.sv
// Directed bench for rate_detector: vector table for basic locking, hand-written
// sequences for code switching, errors, timeout, reset and tolerance windows.
module tb_rate_detector;

  logic       ClockIn;
  logic       Reset;
  logic       PulseIn;

  logic [1:0] speed_a, speed_b;
  logic       locked_a, locked_b;
  logic [5:0] ivl_a, ivl_b;
  logic       mv_a, mv_b;
  logic       err_a, err_b;

  int n_checks;
  int n_fail;

  rate_detector #(.CLOCK_FREQUENCY(8), .TOLERANCE(0), .LOCK_COUNT(2)) dut_a (
    .ClockIn(ClockIn), .Reset(Reset), .PulseIn(PulseIn),
    .SpeedOut(speed_a), .Locked(locked_a), .IntervalOut(ivl_a),
    .MeasValid(mv_a), .Error(err_a)
  );

  rate_detector #(.CLOCK_FREQUENCY(8), .TOLERANCE(1), .LOCK_COUNT(2)) dut_b (
    .ClockIn(ClockIn), .Reset(Reset), .PulseIn(PulseIn),
    .SpeedOut(speed_b), .Locked(locked_b), .IntervalOut(ivl_b),
    .MeasValid(mv_b), .Error(err_b)
  );

  initial ClockIn = 1'b0;
  always #5 ClockIn = ~ClockIn;

  typedef struct {
    logic       rst;
    logic       pulse;
    logic [1:0] speed;
    logic       locked;
    logic [5:0] ivl;
    logic       mv;
    logic       err;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic r, input logic p, input logic [1:0] s,
                              input logic l, input logic [5:0] iv, input logic mv,
                              input logic e);
    vec_t v;
    v.rst = r; v.pulse = p; v.speed = s; v.locked = l; v.ivl = iv; v.mv = mv; v.err = e;
    vecs.push_back(v);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // One clock: drive inputs mid-cycle, sample just after the rising edge
  task automatic cyc(input logic r, input logic p);
    @(negedge ClockIn);
    Reset   = r;
    PulseIn = p;
    @(posedge ClockIn);
    #1;
  endtask

  task automatic gap(input int n);
    for (int i = 0; i < n - 1; i++) cyc(1'b0, 1'b0);
    cyc(1'b0, 1'b1);
    $display("pulse after %0d: A spd=%0d lck=%0d ivl=%0d mv=%0d err=%0d | B spd=%0d lck=%0d ivl=%0d err=%0d",
             n, speed_a, locked_a, ivl_a, mv_a, err_a, speed_b, locked_b, ivl_b, err_b);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    Reset    = 1'b0;
    PulseIn  = 1'b0;

    // Pulses every 8 cycles lock to 01 on the third pulse
    add(1, 0, 0, 0, 0, 0, 0);
    add(0, 1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 7; i++) add(0, 0, 0, 0, 0, 0, 0);
    add(0, 1, 0, 0, 8, 1, 0);
    for (int i = 0; i < 7; i++) add(0, 0, 0, 0, 8, 0, 0);
    add(0, 1, 1, 1, 8, 1, 0);
    for (int i = 0; i < 7; i++) add(0, 0, 1, 1, 8, 0, 0);
    add(0, 1, 1, 1, 8, 1, 0);
    // Continuous pulses lock to 00
    add(1, 0, 0, 0, 0, 0, 0);
    add(0, 1, 0, 0, 0, 0, 0);
    add(0, 1, 0, 0, 1, 1, 0);
    add(0, 1, 0, 1, 1, 1, 0);
    add(0, 1, 0, 1, 1, 1, 0);
    add(0, 0, 0, 1, 1, 0, 0);

    foreach (vecs[i]) begin
      cyc(vecs[i].rst, vecs[i].pulse);
      $display("vec %0d rst=%0d pulse=%0d: spd=%0d lck=%0d ivl=%0d mv=%0d err=%0d",
               i, vecs[i].rst, vecs[i].pulse, speed_a, locked_a, ivl_a, mv_a, err_a);
      chk($sformatf("vec%0d speed", i),  32'(speed_a),  32'(vecs[i].speed));
      chk($sformatf("vec%0d locked", i), 32'(locked_a), 32'(vecs[i].locked));
      chk($sformatf("vec%0d ivl", i),    32'(ivl_a),    32'(vecs[i].ivl));
      chk($sformatf("vec%0d mv", i),     32'(mv_a),     32'(vecs[i].mv));
      chk($sformatf("vec%0d err", i),    32'(err_a),    32'(vecs[i].err));
    end

    // Lock at 10, then switch to 32-cycle pulses and relock at 11
    cyc(1'b1, 1'b0);
    cyc(1'b0, 1'b1);
    gap(16);
    gap(16);
    chk("t3 lock10 locked", 32'(locked_a), 32'd1);
    chk("t3 lock10 speed",  32'(speed_a),  32'd2);
    chk("t3 lock10 ivl",    32'(ivl_a),    32'd16);
    gap(32);
    chk("t3 unlock locked", 32'(locked_a), 32'd0);
    chk("t3 unlock speed",  32'(speed_a),  32'd2);
    chk("t3 unlock ivl",    32'(ivl_a),    32'd32);
    chk("t3 unlock err",    32'(err_a),    32'd0);
    chk("t3 unlock mv",     32'(mv_a),     32'd1);
    gap(32);
    chk("t3 relock locked", 32'(locked_a), 32'd1);
    chk("t3 relock speed",  32'(speed_a),  32'd3);

    // Single bad interval of 5 while locked at 01
    cyc(1'b1, 1'b0);
    cyc(1'b0, 1'b1);
    gap(8);
    gap(8);
    chk("t4 pre locked", 32'(locked_a), 32'd1);
    gap(5);
    chk("t4 bad err",    32'(err_a),    32'd1);
    chk("t4 bad locked", 32'(locked_a), 32'd0);
    chk("t4 bad ivl",    32'(ivl_a),    32'd5);
    chk("t4 bad speed",  32'(speed_a),  32'd1);
    cyc(1'b0, 1'b0);
    chk("t4 err drop",   32'(err_a),    32'd0);
    gap(7);
    chk("t4 first8 locked", 32'(locked_a), 32'd0);
    chk("t4 first8 ivl",    32'(ivl_a),    32'd8);
    gap(8);
    chk("t4 relock locked", 32'(locked_a), 32'd1);
    chk("t4 relock speed",  32'(speed_a),  32'd1);
    chk("t4 relock err",    32'(err_a),    32'd0);

    // Timeout: no pulse for MAXI+1 cycles after lock
    cyc(1'b1, 1'b0);
    cyc(1'b0, 1'b1);
    gap(8);
    gap(8);
    for (int i = 0; i < 32; i++) cyc(1'b0, 1'b0);
    chk("t5 before err",    32'(err_a),    32'd0);
    chk("t5 before locked", 32'(locked_a), 32'd1);
    cyc(1'b0, 1'b0);
    $display("timeout edge: err=%0d lck=%0d spd=%0d", err_a, locked_a, speed_a);
    chk("t5 timeout err",    32'(err_a),    32'd1);
    chk("t5 timeout locked", 32'(locked_a), 32'd0);
    chk("t5 timeout speed",  32'(speed_a),  32'd1);
    cyc(1'b0, 1'b0);
    chk("t5 err drop", 32'(err_a), 32'd0);
    cyc(1'b0, 1'b1);
    chk("t5 ref mv",  32'(mv_a),  32'd0);
    chk("t5 ref err", 32'(err_a), 32'd0);
    gap(8);
    chk("t5 meas mv",  32'(mv_a),  32'd1);
    chk("t5 meas ivl", 32'(ivl_a), 32'd8);

    // Reset together with a pulse mid-measurement
    cyc(1'b1, 1'b0);
    cyc(1'b0, 1'b1);
    gap(8);
    cyc(1'b1, 1'b1);
    chk("t6 rst speed",  32'(speed_a),  32'd0);
    chk("t6 rst locked", 32'(locked_a), 32'd0);
    chk("t6 rst ivl",    32'(ivl_a),    32'd0);
    chk("t6 rst mv",     32'(mv_a),     32'd0);
    chk("t6 rst err",    32'(err_a),    32'd0);
    cyc(1'b0, 1'b1);
    chk("t6 ref mv", 32'(mv_a), 32'd0);
    gap(8);
    chk("t6 first mv",     32'(mv_a),     32'd1);
    chk("t6 first locked", 32'(locked_a), 32'd0);
    gap(8);
    chk("t6 lock locked", 32'(locked_a), 32'd1);
    chk("t6 lock speed",  32'(speed_a),  32'd1);

    // Tolerance of one cycle on the second instance
    cyc(1'b1, 1'b0);
    cyc(1'b0, 1'b1);
    gap(7);
    chk("t7 iv7 ivl", 32'(ivl_b), 32'd7);
    chk("t7 iv7 err", 32'(err_b), 32'd0);
    gap(9);
    chk("t7 iv9 ivl",    32'(ivl_b),    32'd9);
    chk("t7 iv9 locked", 32'(locked_b), 32'd1);
    chk("t7 iv9 speed",  32'(speed_b),  32'd1);
    gap(8);
    chk("t7 iv8 locked", 32'(locked_b), 32'd1);
    chk("t7 iv8 err",    32'(err_b),    32'd0);
    gap(10);
    chk("t7 iv10 err",    32'(err_b),    32'd1);
    chk("t7 iv10 locked", 32'(locked_b), 32'd0);
    chk("t7 iv10 ivl",    32'(ivl_b),    32'd10);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
